// File: rtl/gray_mon_pkg.sv
// gray_mon_pkg -- shared types and helpers for gray_decode_monitor.
//   gray_mon_state_e : monitor FSM states (PRIME, TRACK, FAULT)
//   popcount()       : number of set bits in a GRAY_MAX_W-wide vector
//   gray2bin()       : Gray-to-binary decode of the low 'width' bits
// Callers zero-extend narrower vectors to gray_w_t before calling.
package gray_mon_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gray_w_t;
   typedef logic [5:0]            pop_t;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } gray_mon_state_e;

   function automatic pop_t popcount(input gray_w_t v);
      pop_t cnt;
      cnt = '0;
      for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
         cnt = cnt + pop_t'(v[i]);
      end
      return cnt;
   endfunction

   // b[i] is the XOR of g[width-1:i]; bits at or above width stay 0.
   function automatic gray_w_t gray2bin(input gray_w_t g, input int unsigned width);
      gray_w_t b;
      b = '0;
      for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
         if (i < width) begin
            b[i] = ^(g >> i);
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_decode_monitor_sync.sv
// gray_sync -- plain STAGES-deep flop chain bringing a Gray bus into clk.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears every stage
//   d_in  : WIDTH-bit input, may be asynchronous to clk
//   d_out : last stage of the chain
module gray_sync #(
   parameter int unsigned WIDTH  = 10,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   always_comb begin
      sync_d[0] = d_in;
      for (int unsigned i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/gray_decode_monitor.sv
// gray_decode_monitor -- synchronizes a Gray count, decodes it to binary and
// watches for illegal (multi-bit) Gray steps and binary wraps.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   gray_in    : CBITS Gray count from upstream, possibly asynchronous
//   err_clr    : single-cycle request to leave FAULT
//   bin_out    : registered binary decode, SYNC_STAGES+1 cycles after gray_in
//   bin_valid  : high in TRACK only
//   wrap_pulse : one-cycle pulse on the all-ones -> 0 binary wrap (TRACK only)
//   wrap_cnt   : saturating 16-bit wrap count
//   step_err   : one-cycle pulse on a Gray step with Hamming distance > 1
//   err_sticky : high while in FAULT
// Build option: GRAY_MON_WRAP_CNT_EN builds the wrap counter; without it
// wrap_cnt is tied to 0. SYNC_STAGES must be at least 2.
module gray_decode_monitor
   import gray_mon_pkg::*;
#(
   parameter int unsigned CBITS       = 10,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CBITS-1:0] gray_in,
   input  logic             err_clr,
   output logic [CBITS-1:0] bin_out,
   output logic             bin_valid,
   output logic             wrap_pulse,
   output logic [15:0]      wrap_cnt,
   output logic             step_err,
   output logic             err_sticky
);

   localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 1);
   localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

   logic [CBITS-1:0]   sync_s;
   gray_mon_state_e    state_q, state_d;
   logic [PRIME_W-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0]   p_q, p_d;
   logic [CBITS-1:0]   bin_q, bin_d;
   logic               step_q, step_d;
   logic               wrap_q, wrap_d;
   pop_t               hd;

   gray_sync #(
      .WIDTH  (CBITS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .d_in  (gray_in),
      .d_out (sync_s)
   );

   // bin_q always equals gray2bin(p_q), so comparing bin_q with bin_d
   // is the same as comparing the previous and current synchronized samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      p_d     = sync_s;
      bin_d   = CBITS'(gray2bin(gray_w_t'(sync_s), CBITS));
      hd      = popcount(gray_w_t'(sync_s ^ p_q));

      case (state_q)
         ST_PRIME: begin
            if (cnt_q == PRIME_LAST) begin
               state_d = ST_TRACK;
            end else begin
               cnt_d = cnt_q + PRIME_W'(1);
            end
         end
         ST_TRACK: begin
            // A step error takes priority over any wrap on the same edge.
            if (hd > pop_t'(1)) begin
               step_d  = 1'b1;
               state_d = ST_FAULT;
            end else if ((bin_q == '1) && (bin_d == '0)) begin
               wrap_d = 1'b1;
            end
         end
         ST_FAULT: begin
            if (err_clr) begin
               state_d = ST_PRIME;
            end
         end
         default: begin
            state_d = ST_PRIME;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_PRIME;
         cnt_q   <= '0;
         p_q     <= '0;
         bin_q   <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         bin_q   <= bin_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef GRAY_MON_WRAP_CNT_EN
   logic [15:0] wrap_cnt_q, wrap_cnt_d;

   // Counts on the same edge that raises wrap_pulse; sticks at 16'hFFFF.
   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (wrap_d && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_cnt_q <= '0;
      end else begin
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign wrap_cnt = wrap_cnt_q;
`else
   assign wrap_cnt = '0;
`endif

   assign bin_out    = bin_q;
   assign bin_valid  = (state_q == ST_TRACK);
   assign err_sticky = (state_q == ST_FAULT);
   assign step_err   = step_q;
   assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_gray_decode_monitor.sv
// tb_gray_decode_monitor -- directed bench for gray_decode_monitor
// (CBITS=10, SYNC_STAGES=2). Expected bin_out comes from a 3-deep pipeline
// of the binary values the bench drives (encoded to Gray with b ^ (b >> 1)).
module tb_gray_decode_monitor;

   logic        clk;
   logic        rst;
   logic [9:0]  gray_in;
   logic        err_clr;
   logic [9:0]  bin_out;
   logic        bin_valid;
   logic        wrap_pulse;
   logic [15:0] wrap_cnt;
   logic        step_err;
   logic        err_sticky;

`ifdef GRAY_MON_WRAP_CNT_EN
   localparam logic [15:0] EXP_WRAP = 16'd1;
`else
   localparam logic [15:0] EXP_WRAP = 16'd0;
`endif

   gray_decode_monitor #(
      .CBITS       (10),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gray_in    (gray_in),
      .err_clr    (err_clr),
      .bin_out    (bin_out),
      .bin_valid  (bin_valid),
      .wrap_pulse (wrap_pulse),
      .wrap_cnt   (wrap_cnt),
      .step_err   (step_err),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [9:0] cur_bin;
   logic [9:0] p1, p2, p3;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input logic [9:0] b);
      cur_bin = b;
      gray_in = b ^ (b >> 1);
   endtask

   // Advance one clock, update the expected-bin_out pipeline, check bin_out.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         p1 = '0; p2 = '0; p3 = '0;
      end else begin
         p3 = p2; p2 = p1; p1 = cur_bin;
      end
      #1;
      check_eq("bin_out", 32'(bin_out), 32'(p3));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_bin_out"},    32'(bin_out),    32'd0);
      check_eq({tag, "_bin_valid"},  32'(bin_valid),  32'd0);
      check_eq({tag, "_wrap_pulse"}, 32'(wrap_pulse), 32'd0);
      check_eq({tag, "_wrap_cnt"},   32'(wrap_cnt),   32'd0);
      check_eq({tag, "_step_err"},   32'(step_err),   32'd0);
      check_eq({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n_wrap;
      logic [9:0]  q;
      logic [9:0]  b;

      // Reset: outputs clear without waiting for a clock edge.
      rst = 1'b1; err_clr = 1'b0;
      p1 = '0; p2 = '0; p3 = '0;
      drive(10'd0);
      #1;
      check_all_zero("reset");
      tick(); tick();
      rst = 1'b0;

      // Priming then incrementing count: bin_valid rises on the 3rd edge.
      for (int k = 1; k <= 300; k++) begin
         tick();
         check_eq("prime_valid", 32'(bin_valid), 32'(k >= 3));
         check_eq("count_step_err", 32'(step_err), 32'd0);
         check_eq("count_wrap", 32'(wrap_pulse), 32'd0);
         drive(10'(k));
      end

      // Hold gray_in for 50 cycles.
      for (int k = 0; k < 50; k++) begin
         tick();
         check_eq("hold_step_err", 32'(step_err), 32'd0);
      end
      check_eq("hold_bin_out", 32'(bin_out), 32'd300);
      check_eq("hold_valid", 32'(bin_valid), 32'd1);
      check_eq("pre_wrap_cnt", 32'(wrap_cnt), 32'd0);

      // Count through 1023 -> 0 and hold at 0.
      n_wrap = 0;
      for (int k = 301; k <= 1029; k++) begin
         if (k <= 1024) drive(10'(k));
         q = p3;
         tick();
         check_eq("wrap_pulse", 32'(wrap_pulse), 32'((q == 10'h3FF) && (p3 == 10'd0)));
         check_eq("wrap_step_err", 32'(step_err), 32'd0);
         n_wrap += 32'(wrap_pulse);
      end
      check_eq("wrap_pulses", n_wrap, 32'd1);
      check_eq("wrap_cnt", 32'(wrap_cnt), 32'(EXP_WRAP));
      check_eq("wrap_valid", 32'(bin_valid), 32'd1);

      // Illegal jump 10'h000 -> 10'h003 (binary 2).
      drive(10'd2);
      tick(); check_eq("jump_e1_step", 32'(step_err), 32'd0);
      tick(); check_eq("jump_e2_step", 32'(step_err), 32'd0);
      tick();
      check_eq("jump_step_err", 32'(step_err), 32'd1);
      check_eq("jump_sticky", 32'(err_sticky), 32'd1);
      check_eq("jump_valid", 32'(bin_valid), 32'd0);
      tick();
      check_eq("jump_step_1cyc", 32'(step_err), 32'd0);
      check_eq("jump_sticky2", 32'(err_sticky), 32'd1);

      // Another illegal jump while in FAULT: no further pulse.
      drive(10'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check_eq("fault_no_step", 32'(step_err), 32'd0);
         check_eq("fault_sticky", 32'(err_sticky), 32'd1);
         check_eq("fault_valid", 32'(bin_valid), 32'd0);
      end

      // err_clr in FAULT with a legal count: PRIME for 3 cycles, then TRACK.
      b = 10'd1;
      drive(b);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq("clr_sticky", 32'(err_sticky), 32'd0);
      check_eq("clr_valid", 32'(bin_valid), 32'd0);
      for (int j = 1; j <= 3; j++) begin
         b = b + 10'd1;
         drive(b);
         tick();
         check_eq("reprime_valid", 32'(bin_valid), 32'(j == 3));
      end
      check_eq("clr_wrap_cnt", 32'(wrap_cnt), 32'(EXP_WRAP));
      for (int k = 0; k < 5; k++) begin
         b = b + 10'd1;
         drive(b);
         tick();
         check_eq("track_step_err", 32'(step_err), 32'd0);
         check_eq("track_valid", 32'(bin_valid), 32'd1);
      end

      // err_clr in TRACK is ignored.
      err_clr = 1'b1;
      b = b + 10'd1;
      drive(b);
      tick();
      err_clr = 1'b0;
      check_eq("clr_track_valid", 32'(bin_valid), 32'd1);
      tick();
      check_eq("clr_track_valid2", 32'(bin_valid), 32'd1);

      // Asynchronous reset mid-count, then re-priming.
      b = b + 10'd1;
      drive(b);
      tick();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      p1 = '0; p2 = '0; p3 = '0;
      tick();
      rst = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         b = b + 10'd1;
         drive(b);
         tick();
         check_eq("rst_reprime_valid", 32'(bin_valid), 32'(j == 3));
      end
      for (int k = 0; k < 4; k++) begin
         b = b + 10'd1;
         drive(b);
         tick();
         check_eq("rst_track_step", 32'(step_err), 32'd0);
      end
      check_eq("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
